// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package hex_display_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {S_WAIT, S_DECODE, S_LATCH} scan_state_t;

    // Digit-address width; a single-digit build still carries a 1-bit address.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Nibble write port into the scanner's digit register file; no backpressure.
interface hex_display_scanner_if
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6
);

    localparam int unsigned AW = addr_width(NUM_DIGITS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    nibble_t       wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/decoder.sv
// Combinational hex nibble to active-low seven-segment decoder, bit order gfedcba.
module decoder
    import hex_display_pkg::*;
(
    input  nibble_t i_binary_number,
    output seg_t    o_display
);

    always_comb begin
        o_display = SEG_BLANK;
        unique case (i_binary_number)
            4'h0: o_display = 7'h40;
            4'h1: o_display = 7'h79;
            4'h2: o_display = 7'h24;
            4'h3: o_display = 7'h30;
            4'h4: o_display = 7'h19;
            4'h5: o_display = 7'h12;
            4'h6: o_display = 7'h02;
            4'h7: o_display = 7'h78;
            4'h8: o_display = 7'h00;
            4'h9: o_display = 7'h10;
            4'hA: o_display = 7'h08;
            4'hB: o_display = 7'h03;
            4'hC: o_display = 7'h46;
            4'hD: o_display = 7'h21;
            4'hE: o_display = 7'h06;
            4'hF: o_display = 7'h0E;
            default: o_display = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Stores one nibble per display and time-shares a single decoder across all digits,
// latching each digit's segment word in round-robin order at the prescaled slot rate.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned SCAN_DIV      = 50000,
    parameter seg_t        BLANK_PATTERN = SEG_BLANK
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    hex_display_scanner_if.slave        wr_if,
    input  logic [NUM_DIGITS-1:0]       i_blank_mask,
    output seg_t [NUM_DIGITS-1:0]       o_hex,
    output logic                        o_sweep_done
);

    localparam int unsigned AW = addr_width(NUM_DIGITS);
    localparam int unsigned CW = $clog2(SCAN_DIV);

    localparam logic [AW-1:0] LastIdx    = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   NumDigitsW = (AW + 1)'(NUM_DIGITS);
    localparam logic [CW-1:0] CntMax     = CW'(SCAN_DIV - 1);

    scan_state_t                state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [AW-1:0]              idx_q, idx_d;
    nibble_t                    dec_in_q, dec_in_d;
    nibble_t [NUM_DIGITS-1:0]   digit_q, digit_d;
    seg_t [NUM_DIGITS-1:0]      hex_q, hex_d;
    logic                       sweep_done_q, sweep_done_d;

    logic tick;
    seg_t dec_out;

    assign tick = (cnt_q == CntMax);

    decoder u_decoder (
        .i_binary_number(dec_in_q),
        .o_display      (dec_out)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        dec_in_d     = dec_in_q;
        digit_d      = digit_q;
        hex_d        = hex_q;
        sweep_done_d = 1'b0;

        // Out-of-range addresses are dropped rather than aliased onto a real digit.
        if (wr_if.wr_en && ({1'b0, wr_if.wr_addr} < NumDigitsW)) begin
            digit_d[wr_if.wr_addr] = wr_if.wr_data;
        end

        unique case (state_q)
            S_WAIT: begin
                if (tick) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_in_d = digit_q[idx_q];
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                hex_d[idx_q] = i_blank_mask[idx_q] ? BLANK_PATTERN : dec_out;
                idx_d        = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                sweep_done_d = (idx_q == LastIdx);
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            idx_q        <= '0;
            dec_in_q     <= '0;
            digit_q      <= '0;
            hex_q        <= {NUM_DIGITS{BLANK_PATTERN}};
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dec_in_q     <= dec_in_d;
            digit_q      <= digit_d;
            hex_q        <= hex_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign o_hex        = hex_q;
    assign o_sweep_done = sweep_done_q;

endmodule
